issue_scoreboard: RTL and testbench

In-order issue controller between the decoder and the execution units (alu, shifter, branch, lsu, mul/div). It tracks in-flight register writes per architectural register, blocks read-after-write and saturated write-after-write hazards, and respects per-unit busy. It drains the pipeline before serializing instructions (CSR, mret, sret, fence). The handshake toward execute is valid/ready; the scoreboard is cleared on flush.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/sb_counter.sv | 42 ++++
 rtl/issue_scoreboard.sv | 139 +++++++++++++
 tb/tb_issue_scoreboard.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: unit encoding, scoreboard limits, issue FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  // One-hot execution unit vector width and bit positions
  localparam int NB_UNIT     = 6;
  localparam int UNIT_ALU    = 0;
  localparam int UNIT_SHIFT  = 1;
  localparam int UNIT_BRANCH = 2;
  localparam int UNIT_LSU    = 3;
  localparam int UNIT_MULDIV = 4;
  localparam int UNIT_CSR    = 5;

  // Outstanding writes allowed per architectural register
  localparam int MAX_INFLIGHT = 3;

  typedef enum logic {SB_RUN, SB_DRAIN} sb_state_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down in-flight write counter for one architectural register.
// Latency: new count visible the cycle after inc/dec/clr.
// Backpressure: none; a decrement at zero is dropped, an increment at MAX_CNT is dropped.
module sb_counter #(
  parameter int MAX_CNT = riscv_pkg::MAX_INFLIGHT,
  parameter int CW      = $clog2(MAX_CNT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CNT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dec_ok;

  // Next count: clear wins; simultaneous inc and valid dec cancel out
  always_comb begin
    cnt_d  = cnt_q;
    dec_ok = dec_i & (cnt_q != '0);
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i & ~dec_ok) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else if (dec_ok & ~inc_i) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue gate: blocks RAW, saturated WAW, busy units and serializing ops until drained.
// Latency: issue decision is combinational (0 cycles); counters update on the next edge.
// Backpressure: valid/ready to execute; dec_ready_o only when issued and accepted.
// Optional ISSUE_SCOREBOARD_BYPASS_EN: a same-cycle final write-back releases source/serial hazards.
module issue_scoreboard #(
  parameter int NB_UNIT      = riscv_pkg::NB_UNIT,
  parameter int MAX_INFLIGHT = riscv_pkg::MAX_INFLIGHT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dec_v_i,
  output logic               dec_ready_o,
  input  logic               dec_rd_v_i,
  input  logic [4:0]         dec_rd_adr_i,
  input  logic               dec_rs1_v_i,
  input  logic [4:0]         dec_rs1_adr_i,
  input  logic               dec_rs2_v_i,
  input  logic [4:0]         dec_rs2_adr_i,
  input  logic [NB_UNIT-1:0] dec_unit_i,
  input  logic               dec_serialize_i,
  input  logic [NB_UNIT-1:0] unit_busy_i,
  output logic               issue_v_o,
  input  logic               issue_ready_i,
  output logic [NB_UNIT-1:0] issue_unit_o,
  input  logic               wbk_v_i,
  input  logic [4:0]         wbk_adr_i,
  input  logic               flush_i,
  output logic               stall_raw_o,
  output logic               stall_waw_o,
  output logic               stall_unit_o,
  output logic               stall_serial_o,
  output logic               idle_o,
  output logic               wbk_err_o
);

  localparam int            CW      = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

  logic [CW-1:0] cnt [32];
  logic [31:0]   inc_vec, dec_vec, busy_vec;
  logic          any_busy, rs1_hz, rs2_hz, raw, waw, unit_blk, serial_blk;
  logic          ok, fire, blocked, err_set;
  logic          err_q;
  riscv_pkg::sb_state_t state_q, state_d;

  // x0 is never tracked
  assign cnt[0]     = '0;
  assign inc_vec[0] = 1'b0;
  assign dec_vec[0] = 1'b0;

  for (genvar r = 1; r < 32; r++) begin : g_reg
    // Write-backs during a flush are discarded along with everything else
    assign inc_vec[r] = fire & dec_rd_v_i & (dec_rd_adr_i == 5'(r));
    assign dec_vec[r] = wbk_v_i & ~flush_i & (wbk_adr_i == 5'(r));
    sb_counter #(.MAX_CNT(MAX_INFLIGHT), .CW(CW)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_i   (inc_vec[r]),
      .dec_i   (dec_vec[r]),
      .clr_i   (flush_i),
      .cnt_o   (cnt[r])
    );
  end

  // Per-register "write in flight" flags
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < 32; r++) busy_vec[r] = (cnt[r] != '0);
  end

  assign any_busy = |busy_vec;

`ifdef ISSUE_SCOREBOARD_BYPASS_EN
  logic [31:0] last_vec;

  // Registers whose final outstanding write retires this cycle
  always_comb begin
    last_vec = '0;
    for (int r = 0; r < 32; r++) last_vec[r] = dec_vec[r] & (cnt[r] == CW'(1));
  end

  assign rs1_hz     = dec_rs1_v_i & busy_vec[dec_rs1_adr_i] & ~last_vec[dec_rs1_adr_i];
  assign rs2_hz     = dec_rs2_v_i & busy_vec[dec_rs2_adr_i] & ~last_vec[dec_rs2_adr_i];
  assign serial_blk = dec_serialize_i & |(busy_vec & ~last_vec);
`else
  assign rs1_hz     = dec_rs1_v_i & busy_vec[dec_rs1_adr_i];
  assign rs2_hz     = dec_rs2_v_i & busy_vec[dec_rs2_adr_i];
  assign serial_blk = dec_serialize_i & any_busy;
`endif

  assign raw      = rs1_hz | rs2_hz;
  assign waw      = dec_rd_v_i & (dec_rd_adr_i != 5'd0) & (cnt[dec_rd_adr_i] == CNT_MAX);
  assign unit_blk = |(dec_unit_i & unit_busy_i);
  assign ok       = dec_v_i & ~raw & ~waw & ~unit_blk & ~serial_blk & ~flush_i;
  assign fire     = ok & issue_ready_i;
  assign blocked  = dec_v_i & ~flush_i & ~ok;

  assign issue_v_o    = ok;
  assign dec_ready_o  = fire;
  assign issue_unit_o = ok ? dec_unit_i : '0;

  // Exactly one stall cause per blocked cycle: serial > raw > waw > unit
  assign stall_serial_o = blocked & serial_blk;
  assign stall_raw_o    = blocked & ~serial_blk & raw;
  assign stall_waw_o    = blocked & ~serial_blk & ~raw & waw;
  assign stall_unit_o   = blocked & ~serial_blk & ~raw & ~waw & unit_blk;

  // Drain FSM next state: enter on a blocked serializer, leave once nothing is in flight
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = riscv_pkg::SB_RUN;
    end else begin
      case (state_q)
        riscv_pkg::SB_RUN:   if (dec_v_i & dec_serialize_i & any_busy) state_d = riscv_pkg::SB_DRAIN;
        riscv_pkg::SB_DRAIN: if (!any_busy) state_d = riscv_pkg::SB_RUN;
        default:             state_d = riscv_pkg::SB_RUN;
      endcase
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= riscv_pkg::SB_RUN;
    else          state_q <= state_d;
  end

  assign err_set = wbk_v_i & ~flush_i & (wbk_adr_i != 5'd0) & ~busy_vec[wbk_adr_i];

  // Sticky flag for a write-back with nothing outstanding on its register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_q | err_set;
  end

  assign wbk_err_o = err_q;
  assign idle_o    = ~any_busy & (state_q == riscv_pkg::SB_RUN);

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  localparam int NBU  = 6;
  localparam int MAXI = 3;
  localparam int LSU  = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           dec_v_i, dec_ready_o, dec_rd_v_i, dec_rs1_v_i, dec_rs2_v_i, dec_serialize_i;
  logic [4:0]     dec_rd_adr_i, dec_rs1_adr_i, dec_rs2_adr_i, wbk_adr_i;
  logic [NBU-1:0] dec_unit_i, unit_busy_i, issue_unit_o;
  logic           issue_v_o, issue_ready_i, wbk_v_i, flush_i;
  logic           stall_raw_o, stall_waw_o, stall_unit_o, stall_serial_o, idle_o, wbk_err_o;

  issue_scoreboard dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .dec_v_i         (dec_v_i),
    .dec_ready_o     (dec_ready_o),
    .dec_rd_v_i      (dec_rd_v_i),
    .dec_rd_adr_i    (dec_rd_adr_i),
    .dec_rs1_v_i     (dec_rs1_v_i),
    .dec_rs1_adr_i   (dec_rs1_adr_i),
    .dec_rs2_v_i     (dec_rs2_v_i),
    .dec_rs2_adr_i   (dec_rs2_adr_i),
    .dec_unit_i      (dec_unit_i),
    .dec_serialize_i (dec_serialize_i),
    .unit_busy_i     (unit_busy_i),
    .issue_v_o       (issue_v_o),
    .issue_ready_i   (issue_ready_i),
    .issue_unit_o    (issue_unit_o),
    .wbk_v_i         (wbk_v_i),
    .wbk_adr_i       (wbk_adr_i),
    .flush_i         (flush_i),
    .stall_raw_o     (stall_raw_o),
    .stall_waw_o     (stall_waw_o),
    .stall_unit_o    (stall_unit_o),
    .stall_serial_o  (stall_serial_o),
    .idle_o          (idle_o),
    .wbk_err_o       (wbk_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding writes per register, drain flag, sticky error
  int  mcnt [32];
  bit  mdrain, merr;
  bit  e_ok;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  function automatic int total();
    int t = 0;
    for (int r = 1; r < 32; r++) t += mcnt[r];
    return t;
  endfunction

  task automatic clr_in();
    dec_v_i = 0; dec_rd_v_i = 0; dec_rd_adr_i = 0; dec_rs1_v_i = 0; dec_rs1_adr_i = 0;
    dec_rs2_v_i = 0; dec_rs2_adr_i = 0; dec_unit_i = 0; dec_serialize_i = 0;
    unit_busy_i = 0; issue_ready_i = 1; wbk_v_i = 0; wbk_adr_i = 0; flush_i = 0;
  endtask

  task automatic set_ins(input int rd, input int rs1, input int rs2, input int unit, input bit ser);
    dec_v_i = 1;
    dec_rd_v_i = (rd >= 0);  dec_rd_adr_i  = (rd >= 0)  ? 5'(rd)  : 5'd0;
    dec_rs1_v_i = (rs1 >= 0); dec_rs1_adr_i = (rs1 >= 0) ? 5'(rs1) : 5'd0;
    dec_rs2_v_i = (rs2 >= 0); dec_rs2_adr_i = (rs2 >= 0) ? 5'(rs2) : 5'd0;
    dec_unit_i = NBU'(1) << unit;
    dec_serialize_i = ser;
  endtask

  task automatic wbk(input int adr);
    wbk_v_i = 1; wbk_adr_i = 5'(adr);
  endtask

  // Compare every DUT output against the model, 1 time unit after the falling edge drive
  task automatic eval();
    int  tot;
    bit  h1, h2, rawe, wawe, unite, sere, blk;
    logic [NBU-1:0] eu;
    #1;
    tot = total();
    h1 = dec_rs1_v_i && mcnt[dec_rs1_adr_i] > 0;
    h2 = dec_rs2_v_i && mcnt[dec_rs2_adr_i] > 0;
    sere = dec_serialize_i && tot > 0;
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    if (wbk_v_i && !flush_i && wbk_adr_i == dec_rs1_adr_i && mcnt[dec_rs1_adr_i] == 1) h1 = 0;
    if (wbk_v_i && !flush_i && wbk_adr_i == dec_rs2_adr_i && mcnt[dec_rs2_adr_i] == 1) h2 = 0;
    if (tot == 1 && wbk_v_i && !flush_i && mcnt[wbk_adr_i] == 1) sere = 0;
`endif
    rawe  = h1 || h2;
    wawe  = dec_rd_v_i && dec_rd_adr_i != 0 && mcnt[dec_rd_adr_i] == MAXI;
    unite = (dec_unit_i & unit_busy_i) != 0;
    e_ok  = dec_v_i && !rawe && !wawe && !unite && !sere && !flush_i;
    blk   = dec_v_i && !flush_i && !e_ok;
    chk("issue_v", issue_v_o, e_ok);
    chk("dec_ready", dec_ready_o, e_ok && issue_ready_i);
    chk("stall_serial", stall_serial_o, blk && sere);
    chk("stall_raw", stall_raw_o, blk && !sere && rawe);
    chk("stall_waw", stall_waw_o, blk && !sere && !rawe && wawe);
    chk("stall_unit", stall_unit_o, blk && !sere && !rawe && !wawe && unite);
    chk("idle", idle_o, tot == 0 && !mdrain);
    chk("wbk_err", wbk_err_o, merr);
    eu = e_ok ? dec_unit_i : '0;
    checks++;
    if (issue_unit_o !== eu) begin
      errors++;
      $display("FAIL issue_unit actual=%b required=%b", issue_unit_o, eu);
    end
  endtask

  // Clock edge, then advance the model with the inputs that were applied
  task automatic adv();
    int  tot, d;
    bit  inc, decok;
    @(posedge clk);
    tot = total();
    if (flush_i) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      mdrain = 0;
    end else begin
      mdrain = mdrain ? (tot != 0) : (dec_v_i && dec_serialize_i && tot > 0);
      inc   = e_ok && issue_ready_i && dec_rd_v_i && dec_rd_adr_i != 0;
      decok = wbk_v_i && wbk_adr_i != 0 && mcnt[wbk_adr_i] > 0;
      if (wbk_v_i && wbk_adr_i != 0 && mcnt[wbk_adr_i] == 0) merr = 1;
      for (int r = 1; r < 32; r++) begin
        d = ((inc && dec_rd_adr_i == 5'(r)) ? 1 : 0) - ((decok && wbk_adr_i == 5'(r)) ? 1 : 0);
        mcnt[r] = mcnt[r] + d;
        if (mcnt[r] > MAXI) mcnt[r] = MAXI;
      end
    end
    @(negedge clk);
    clr_in();
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_in();
    reset_n = 0;
    #1;
    chk("reset_idle", idle_o, 1'b1);
    chk("reset_issue_v", issue_v_o, 1'b0);
    chk("reset_wbk_err", wbk_err_o, 1'b0);
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    mdrain = 0; merr = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic drain_all();
    int guard = 0;
    while (total() > 0 && guard < 200) begin
      for (int r = 1; r < 32; r++) if (mcnt[r] > 0 && !wbk_v_i) wbk(r);
      step();
      guard++;
    end
  endtask

  initial begin
    int r0;
    clr_in();
    do_reset();

    // Reset state, then a plain add x5
    eval(); chk("d_reset_idle", idle_o, 1'b1); chk("d_reset_iv", issue_v_o, 1'b0); adv();
    set_ins(5, 1, 2, 0, 0); eval(); chk("d_add_issue", issue_v_o, 1'b1); adv();
    eval(); chk("d_add_busy", idle_o, 1'b0); adv();

    // RAW on x5, released by its write-back
    set_ins(6, 5, -1, 0, 0); eval(); chk("d_raw_stall", stall_raw_o, 1'b1); chk("d_raw_iv", issue_v_o, 1'b0); adv();
    set_ins(6, 5, -1, 0, 0); wbk(5); eval();
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    chk("d_raw_wbk_cycle", issue_v_o, 1'b1);
`else
    chk("d_raw_wbk_cycle", issue_v_o, 1'b0);
`endif
    adv();
    set_ins(6, 5, -1, 0, 0); eval(); chk("d_raw_release", issue_v_o, 1'b1); adv();
    drain_all();

    // WAW saturation on x7
    for (int i = 0; i < 3; i++) begin
      set_ins(7, -1, -1, 1, 0); eval(); chk("d_waw_fill", issue_v_o, 1'b1); adv();
    end
    set_ins(7, -1, -1, 1, 0); eval(); chk("d_waw_stall", stall_waw_o, 1'b1); adv();
    set_ins(7, -1, -1, 1, 0); wbk(7); eval(); chk("d_waw_wbk_cycle", stall_waw_o, 1'b1); adv();
    set_ins(7, -1, -1, 1, 0); eval(); chk("d_waw_release", issue_v_o, 1'b1); adv();
    drain_all();

    // Serializing csr waits for two in-flight writes
    set_ins(1, -1, -1, 0, 0); step();
    set_ins(2, -1, -1, 0, 0); step();
    set_ins(-1, -1, -1, 5, 1); eval(); chk("d_ser_stall", stall_serial_o, 1'b1); adv();
    set_ins(-1, -1, -1, 5, 1); eval(); chk("d_ser_drain_idle", idle_o, 1'b0); chk("d_ser_stall2", stall_serial_o, 1'b1); adv();
    set_ins(-1, -1, -1, 5, 1); wbk(1); step();
    set_ins(-1, -1, -1, 5, 1); wbk(2); eval();
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    chk("d_ser_last_wbk", issue_v_o, 1'b1);
`else
    chk("d_ser_last_wbk", issue_v_o, 1'b0);
`endif
    adv();
    set_ins(-1, -1, -1, 5, 1); eval(); chk("d_ser_issue", issue_v_o, 1'b1); chk("d_ser_still_drain", idle_o, 1'b0); adv();
    eval(); chk("d_ser_run", idle_o, 1'b1); adv();

    // Busy LSU, then simultaneous fire and write-back on x9
    set_ins(8, -1, -1, LSU, 0); unit_busy_i = NBU'(1) << LSU; eval(); chk("d_unit_stall", stall_unit_o, 1'b1); adv();
    set_ins(8, -1, -1, LSU, 0); eval(); chk("d_unit_release", issue_v_o, 1'b1); adv();
    set_ins(9, -1, -1, 0, 0); step();
    set_ins(9, -1, -1, 0, 0); wbk(9); eval(); chk("d_x9_fire", issue_v_o, 1'b1); adv();
    wbk(8); step();
    wbk(9); step();
    eval(); chk("d_x9_net_idle", idle_o, 1'b1); chk("d_x9_no_err", wbk_err_o, 1'b0); adv();

    // Flush out of DRAIN with x3 twice in flight
    set_ins(3, -1, -1, 0, 0); step();
    set_ins(3, -1, -1, 0, 0); step();
    set_ins(-1, -1, -1, 5, 1); step();
    set_ins(-1, -1, -1, 5, 1); flush_i = 1; wbk(4); eval();
    chk("d_flush_iv", issue_v_o, 1'b0); chk("d_flush_nostall", stall_serial_o, 1'b0); adv();
    eval(); chk("d_flush_idle", idle_o, 1'b1); chk("d_flush_wbk_ignored", wbk_err_o, 1'b0); adv();
    wbk(3); step();
    eval(); chk("d_flush_err", wbk_err_o, 1'b1); adv();

    do_reset();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) do_reset();
      if ($urandom_range(0, 99) < 80) begin
        set_ins(($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 7)) : -1,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                int'($urandom_range(0, NBU - 1)),
                $urandom_range(0, 19) == 0);
      end
      for (int u = 0; u < NBU; u++) unit_busy_i[u] = ($urandom_range(0, 99) < 12);
      issue_ready_i = ($urandom_range(0, 99) < 80);
      flush_i = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 40) begin
        r0 = int'($urandom_range(0, 7));
        if (total() > 0 && $urandom_range(0, 99) < 92) begin
          r0 = int'($urandom_range(1, 31));
          while (mcnt[r0] == 0) r0 = (r0 % 31) + 1;
        end
        wbk(r0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
